gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Parametrised dynamic branch direction predictor for the pipelined CPU, a generalisation of the single 2-bit saturating counter. It holds a pattern history table (PHT) of 2^IDX_W saturating counters of CNT_W bits each. The table is indexed either by PC alone (bimodal) or by PC XOR a global history register (gshare). A saturating misprediction counter is included for performance measurement. The ID stage calls it for prediction, and the resolving stage (EX) sends updates back.

## Interface
- CNT_W, 2: counter width in bits (1..4).
- IDX_W, 6: PHT index width; depth = 2^IDX_W.
- HIST_W, 6: global history length (1..IDX_W).
- MODE, 1: 0 = bimodal (index = PC bits only); 1 = gshare.
- INIT, 2^CNT_W-1: reset value of every PHT counter (strongly taken by default).
- MISS_W, 16: misprediction counter width.

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- pc_i  in  32  PC of the branch being predicted
- predict_o  out  1  predicted direction (1 = taken)
- predict_idx_o  out  IDX_W  PHT index used for this prediction; the pipeline carries it to update
- update_i  in  1  resolved branch update strobe
- update_idx_i  in  IDX_W  index returned from predict_idx_o of that branch
- update_pred_i  in  1  direction that was predicted for that branch
- result_i  in  1  actual outcome (1 = taken)
- ghr_o  out  HIST_W  current global history
- miss_cnt_o  out  MISS_W  saturating count of mispredictions

## Operation
- Index formation: base = pc_i[IDX_W+1:2], since instructions are word aligned.
  - MODE 0: predict_idx_o = base.
  - MODE 1: predict_idx_o = base ^ {{(IDX_W-HIST_W){0}}, ghr}.
- predict_o = MSB of PHT[predict_idx_o]. This is a combinational read of the registered state.
- On a posedge with update_i = 1:
  - result_i = 1: PHT[update_idx_i] increments, saturating at 2^CNT_W-1.
  - result_i = 0: PHT[update_idx_i] decrements, saturating at 0.
  - ghr <= {ghr[HIST_W-2:0], result_i}. The GHR updates at resolution (non-speculative) in both modes; in MODE 0 it is tracked but not used for indexing.
  - If update_pred_i != result_i, miss_cnt increments, saturating at 2^MISS_W-1 with no wrap.
- update_i = 0: no state change. result_i, update_pred_i and update_idx_i are ignored.
- The update always uses update_idx_i and never recomputes an index from the current GHR. Prediction and update therefore hit the same entry even when the history moved in between.
- Only one entry changes per cycle. All other entries hold.
- Reset (asynchronous, any cycle, including while update_i is high):
  - every PHT entry <= INIT; ghr <= 0; miss_cnt <= 0.
  - predict_o therefore resets to INIT[CNT_W-1] (1 by default).
  - The update in flight is discarded.

## Timing
- Prediction latency is 0 cycles: predict_o and predict_idx_o follow pc_i and ghr combinationally.
- Update latency is 1 cycle: a new counter, GHR or miss_cnt value is visible on outputs in the cycle after the update edge.
- Predict and update to the same index in the same cycle: predict_o shows the pre-update value. There is no bypass.
- Back-to-back updates on consecutive cycles to the same index each apply fully, e.g. two decrements from 3 give 1.
- No handshake or stall. An update is accepted every cycle that update_i = 1.
- Outputs after reset deassertion: predict_o = INIT MSB, ghr_o = 0, miss_cnt_o = 0.

## Test plan
- Reset with defaults, pc_i = 0x40 -> predict_o = 1, predict_idx_o = 0x10, ghr_o = 0, miss_cnt_o = 0.
- Saturation, CNT_W = 2, idx 5:
  - 4 updates with result 0 -> counter 3→2→1→0→0; predict_o flips to 0 after the 2nd update.
  - 4 updates with result 1 -> counter 0→1→2→3→3; predict_o = 1 after the 2nd update.
- gshare indexing, MODE 1, HIST_W = 6:
  - updates with results 1,0,1 -> ghr_o = 0b000101.
  - then pc_i = 0x40 -> predict_idx_o = 0x10 ^ 0x05 = 0x15.
  - MODE 0 under the same stimulus -> predict_idx_o = 0x10.
- Same-cycle predict/update on idx 0x15: predict_o reads the old value that cycle and the new value the next cycle. Entries other than 0x15 are unchanged.
- miss_cnt, MISS_W = 2: 5 updates with update_pred_i != result_i -> miss_cnt_o = 1,2,3,3,3. Updates with update_pred_i == result_i leave it unchanged.
- rst_i pulsed asynchronously mid-cycle while update_i = 1 -> all entries return to INIT, ghr = 0, miss_cnt = 0, with no partial update applied.

Source files
------------

// File: rtl/gshare_predictor.sv
// Pattern history table of saturating counters, indexed by PC (bimodal) or by PC XOR global
// history (gshare). Updates come back from the resolving stage and carry the index they predicted with.
module gshare_predictor #(
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned HIST_W = 6,
  parameter int unsigned MODE   = 1,
  parameter int unsigned INIT   = (2 ** CNT_W) - 1,
  parameter int unsigned MISS_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       pc_i,
  output logic              predict_o,
  output logic [IDX_W-1:0]  predict_idx_o,
  input  logic              update_i,
  input  logic [IDX_W-1:0]  update_idx_i,
  input  logic              update_pred_i,
  input  logic              result_i,
  output logic [HIST_W-1:0] ghr_o,
  output logic [MISS_W-1:0] miss_cnt_o
);

  localparam int unsigned      Depth   = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(INIT);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  logic [CNT_W-1:0]  pht_q [Depth];
  logic [CNT_W-1:0]  cnt_cur, cnt_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [IDX_W-1:0]  base_idx, hist_idx;
  logic              unused_pc;

  // Word-aligned fetch: the two LSBs and the bits above the index never select an entry.
  assign base_idx  = pc_i[IDX_W+1:2];
  assign unused_pc = ^{pc_i[31:IDX_W+2], pc_i[1:0]};

  generate
    if (MODE == 1) begin : g_gshare
      assign hist_idx = IDX_W'(ghr_q);
    end else begin : g_bimodal
      assign hist_idx = '0;
    end
  endgenerate

  assign predict_idx_o = base_idx ^ hist_idx;
  assign predict_o     = pht_q[predict_idx_o][CNT_W-1];
  assign ghr_o         = ghr_q;
  assign miss_cnt_o    = miss_q;

  always_comb begin
    cnt_cur = pht_q[update_idx_i];
    cnt_d   = cnt_cur;
    if (result_i) begin
      if (cnt_cur != CntMax) cnt_d = cnt_cur + CNT_W'(1);
    end else begin
      if (cnt_cur != '0) cnt_d = cnt_cur - CNT_W'(1);
    end
  end

  generate
    if (HIST_W == 1) begin : g_hist_one
      assign ghr_d = result_i;
    end else begin : g_hist_shift
      assign ghr_d = {ghr_q[HIST_W-2:0], result_i};
    end
  endgenerate

  always_comb begin
    miss_d = miss_q;
    if ((update_pred_i != result_i) && (miss_q != {MISS_W{1'b1}})) begin
      miss_d = miss_q + MISS_W'(1);
    end
  end

  // History is trained at resolution, so it is identical in both modes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        pht_q[i] <= CntInit;
      end
      ghr_q  <= '0;
      miss_q <= '0;
    end else if (update_i) begin
      pht_q[update_idx_i] <= cnt_d;
      ghr_q               <= ghr_d;
      miss_q              <= miss_d;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Two predictors (gshare default, and bimodal with a 2-bit miss counter) share update traffic and
// are compared against an integer model of the counter table, history and miss count.
module tb_gshare_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_a, pc_b;
  logic        pred_a, pred_b;
  logic [5:0]  pidx_a, pidx_b;
  logic        update_i;
  logic [5:0]  update_idx_i;
  logic        update_pred_i;
  logic        result_i;
  logic [5:0]  ghr_a, ghr_b;
  logic [15:0] miss_a;
  logic [1:0]  miss_b;

  int total = 0;
  int bad   = 0;

  int pht_a [64];
  int pht_b [64];
  int ghr_m;
  int miss_a_m;
  int miss_b_m;

  always #5 clk_i = ~clk_i;

  gshare_predictor dut_a (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_a),
    .predict_o     (pred_a),
    .predict_idx_o (pidx_a),
    .update_i      (update_i),
    .update_idx_i  (update_idx_i),
    .update_pred_i (update_pred_i),
    .result_i      (result_i),
    .ghr_o         (ghr_a),
    .miss_cnt_o    (miss_a)
  );

  gshare_predictor #(.MODE(0), .MISS_W(2)) dut_b (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_b),
    .predict_o     (pred_b),
    .predict_idx_o (pidx_b),
    .update_i      (update_i),
    .update_idx_i  (update_idx_i),
    .update_pred_i (update_pred_i),
    .result_i      (result_i),
    .ghr_o         (ghr_b),
    .miss_cnt_o    (miss_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      pht_a[i] = 3;
      pht_b[i] = 3;
    end
    ghr_m    = 0;
    miss_a_m = 0;
    miss_b_m = 0;
  endtask

  task automatic model_update();
    int i;
    i = int'(update_idx_i);
    if (result_i) begin
      pht_a[i] = (pht_a[i] < 3) ? pht_a[i] + 1 : 3;
      pht_b[i] = (pht_b[i] < 3) ? pht_b[i] + 1 : 3;
    end else begin
      pht_a[i] = (pht_a[i] > 0) ? pht_a[i] - 1 : 0;
      pht_b[i] = (pht_b[i] > 0) ? pht_b[i] - 1 : 0;
    end
    ghr_m = (ghr_m * 2 + int'(result_i)) % 64;
    if (update_pred_i != result_i) begin
      if (miss_a_m < 65535) miss_a_m++;
      if (miss_b_m < 3) miss_b_m++;
    end
  endtask

  // One clock edge; the model follows whatever the inputs held at that edge.
  task automatic tick();
    @(posedge clk_i);
    if (!rst_i && update_i) model_update();
    #1;
  endtask

  // Point both PCs at table entry e and compare direction and index.
  task automatic check_entry(input int e);
    int ha;
    ha   = (e ^ ghr_m) & 63;
    pc_a = ($urandom & 32'hFFFF_FF03) | (ha << 2);
    pc_b = ($urandom & 32'hFFFF_FF03) | (e << 2);
    #1;
    chk("pred_a", pred_a, (pht_a[e] >= 2) ? 1 : 0);
    chk("idx_a", pidx_a, e);
    chk("pred_b", pred_b, (pht_b[e] >= 2) ? 1 : 0);
    chk("idx_b", pidx_b, e);
  endtask

  task automatic check_state();
    chk("ghr_a", ghr_a, ghr_m);
    chk("ghr_b", ghr_b, ghr_m);
    chk("miss_a", miss_a, miss_a_m);
    chk("miss_b", miss_b, miss_b_m);
  endtask

  initial begin
    int sat_dn [4];
    int sat_up [4];
    int miss_exp [5];
    int pc, ea, eb;
    sat_dn   = '{1, 0, 0, 0};
    sat_up   = '{0, 1, 1, 1};
    miss_exp = '{1, 2, 3, 3, 3};

    // Reset, checked before any clock edge.
    rst_i = 1'b1;
    update_i = 1'b0;
    update_idx_i = '0;
    update_pred_i = 1'b0;
    result_i = 1'b0;
    pc_a = 32'h40;
    pc_b = 32'h40;
    model_reset();
    #3;
    chk("rst_pred_a", pred_a, 1);
    chk("rst_idx_a", pidx_a, 6'h10);
    chk("rst_pred_b", pred_b, 1);
    chk("rst_idx_b", pidx_b, 6'h10);
    chk("rst_ghr", ghr_a, 0);
    chk("rst_miss", miss_a, 0);
    #9;
    rst_i = 1'b0;
    tick();

    // History 1,0,1 shapes the gshare index.
    update_i = 1'b1;
    update_idx_i = 6'h3f;
    update_pred_i = 1'b1;
    result_i = 1'b1; tick();
    result_i = 1'b0; tick();
    result_i = 1'b1; tick();
    update_i = 1'b0;
    pc_a = 32'h40;
    pc_b = 32'h40;
    #1;
    chk("ghr_101_a", ghr_a, 6'b000101);
    chk("ghr_101_b", ghr_b, 6'b000101);
    chk("gshare_idx", pidx_a, 6'h15);
    chk("bimodal_idx", pidx_b, 6'h10);
    check_state();

    // Saturation on entry 5, down then up.
    update_idx_i = 6'd5;
    for (int k = 0; k < 4; k++) begin
      update_i = 1'b1;
      result_i = 1'b0;
      update_pred_i = 1'b1;
      tick();
      update_i = 1'b0;
      check_entry(5);
      chk("sat_dn_a", pred_a, sat_dn[k]);
      chk("sat_dn_b", pred_b, sat_dn[k]);
    end
    for (int k = 0; k < 4; k++) begin
      update_i = 1'b1;
      result_i = 1'b1;
      update_pred_i = 1'b0;
      tick();
      update_i = 1'b0;
      check_entry(5);
      chk("sat_up_a", pred_a, sat_up[k]);
      chk("sat_up_b", pred_b, sat_up[k]);
    end
    check_state();

    // Same-cycle predict and update of entry 0x15: no bypass.
    tick();
    update_i = 1'b1;
    update_idx_i = 6'h15;
    result_i = 1'b0;
    update_pred_i = 1'b0;
    tick();
    pc_a = ((6'h15 ^ ghr_m) & 63) << 2;
    pc_b = 32'h15 << 2;
    #1;
    chk("same_old_a", pred_a, 1);
    chk("same_old_b", pred_b, 1);
    tick();
    update_i = 1'b0;
    check_entry(6'h15);
    chk("same_new_a", pred_a, 0);
    chk("same_new_b", pred_b, 0);
    for (int e = 0; e < 64; e++) check_entry(e);
    check_state();

    // Asynchronous reset mid-cycle with an update pending.
    tick();
    update_i = 1'b1;
    update_idx_i = 6'd7;
    result_i = 1'b0;
    update_pred_i = 1'b1;
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_ghr", ghr_a, 0);
    chk("arst_miss_a", miss_a, 0);
    chk("arst_miss_b", miss_b, 0);
    model_reset();
    tick();
    update_i = 1'b0;
    #2;
    rst_i = 1'b0;
    for (int e = 0; e < 64; e++) check_entry(e);
    check_state();

    // Miss counter saturation on the 2-bit instance.
    tick();
    for (int k = 0; k < 5; k++) begin
      update_i = 1'b1;
      update_idx_i = 6'($urandom);
      result_i = 1'($urandom);
      update_pred_i = ~result_i;
      tick();
      chk("miss_sat_b", miss_b, miss_exp[k]);
      chk("miss_sat_a", miss_a, k + 1);
    end
    for (int k = 0; k < 3; k++) begin
      update_idx_i = 6'($urandom);
      result_i = 1'($urandom);
      update_pred_i = result_i;
      tick();
      chk("miss_hold_b", miss_b, 3);
      chk("miss_hold_a", miss_a, 5);
    end
    update_i = 1'b0;
    check_state();

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      update_i = ($urandom_range(3) != 0);
      update_idx_i = 6'($urandom_range(15));
      result_i = 1'($urandom);
      update_pred_i = 1'($urandom);
      pc = $urandom;
      pc_a = pc;
      pc_b = ~pc;
      ea = ((pc >> 2) & 63) ^ ghr_m;
      eb = ((~pc) >> 2) & 63;
      #1;
      chk("rnd_idx_a", pidx_a, ea);
      chk("rnd_pred_a", pred_a, (pht_a[ea] >= 2) ? 1 : 0);
      chk("rnd_idx_b", pidx_b, eb);
      chk("rnd_pred_b", pred_b, (pht_b[eb] >= 2) ? 1 : 0);
      tick();
      check_state();
    end
    update_i = 1'b0;
    for (int e = 0; e < 64; e++) check_entry(e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
